// File: rtl/matrix_store_arbiter_pkg.sv
// Shared types and address helpers for the matrix storage write path.
// The slot table and the top-level arbiter both use these helpers, so they agree on the RAM layout.
package matrix_store_arbiter_pkg;

   localparam int MAX_DIM       = 5;
   localparam int SLOTS_PER_DIM = 2;
   localparam int ELEM_W        = 8;
   localparam int ADDR_W        = 11;

   typedef enum logic {SRC_IN, SRC_GEN} src_e;

   typedef enum logic [1:0] {IDLE, WRITE, COMMIT} state_e;

   function automatic int class_idx(input int m, input int n, input int max_dim);
      return (m - 1) * max_dim + (n - 1);
   endfunction

   // Each (m,n) class owns slots * max_dim^2 consecutive words; each slot owns max_dim^2 words.
   function automatic int base_addr(input int m, input int n, input int slot,
                                    input int max_dim, input int slots);
      return class_idx(m, n, max_dim) * slots * max_dim * max_dim + slot * max_dim * max_dim;
   endfunction

endpackage

// File: rtl/matrix_store_arbiter_slot_table.sv
// Per-(m,n) class bookkeeping: the next slot to overwrite and a saturating count of stored matrices.
// The table has one commit port and a combinational query port.
module matrix_slot_table #(
   parameter int  MAX_DIM       = matrix_store_arbiter_pkg::MAX_DIM,
   parameter int  SLOTS_PER_DIM = matrix_store_arbiter_pkg::SLOTS_PER_DIM,
   localparam int DIM_W         = $clog2(MAX_DIM + 1),
   localparam int NUM_CLS       = MAX_DIM * MAX_DIM,
   localparam int CLS_W         = $clog2(NUM_CLS),
   localparam int PTR_W         = (SLOTS_PER_DIM > 1) ? $clog2(SLOTS_PER_DIM) : 1,
   localparam int CNT_W         = $clog2(SLOTS_PER_DIM + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             commit_en,
   input  logic [CLS_W-1:0] cls,
   output logic [PTR_W-1:0] ptr,
   input  logic [DIM_W-1:0] q_m,
   input  logic [DIM_W-1:0] q_n,
   output logic [CNT_W-1:0] q_count
);
   import matrix_store_arbiter_pkg::*;

   logic [PTR_W-1:0] wr_ptr [NUM_CLS];
   logic [CNT_W-1:0] count  [NUM_CLS];

   assign ptr = wr_ptr[cls];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CLS; i++) begin
            wr_ptr[i] <= '0;
            count[i]  <= '0;
         end
      end else if (commit_en) begin
         wr_ptr[cls] <= (wr_ptr[cls] == PTR_W'(SLOTS_PER_DIM - 1)) ? '0 : wr_ptr[cls] + 1'b1;
         if (count[cls] != CNT_W'(SLOTS_PER_DIM))
            count[cls] <= count[cls] + 1'b1;
      end
   end

   always_comb begin
      q_count = '0;
      if (q_m != '0 && q_m <= DIM_W'(MAX_DIM) && q_n != '0 && q_n <= DIM_W'(MAX_DIM))
         q_count = count[CLS_W'(class_idx(int'(q_m), int'(q_n), MAX_DIM))];
   end

endmodule

// File: rtl/matrix_store_arbiter.sv
// Round-robin write arbiter between the matrix-input path and a one-entry generator buffer.
// Each granted matrix is serialised into the single-port storage RAM one element per cycle.
module matrix_store_arbiter #(
   parameter int  MAX_DIM       = matrix_store_arbiter_pkg::MAX_DIM,
   parameter int  SLOTS_PER_DIM = matrix_store_arbiter_pkg::SLOTS_PER_DIM,
   parameter int  ELEM_W        = matrix_store_arbiter_pkg::ELEM_W,
   parameter int  ADDR_W        = matrix_store_arbiter_pkg::ADDR_W,
   localparam int DIM_W         = $clog2(MAX_DIM + 1),
   localparam int FLAT_W        = MAX_DIM * MAX_DIM * ELEM_W,
   localparam int PTR_W         = (SLOTS_PER_DIM > 1) ? $clog2(SLOTS_PER_DIM) : 1,
   localparam int CNT_W         = $clog2(SLOTS_PER_DIM + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_req,
   input  logic [FLAT_W-1:0] in_flat,
   input  logic [DIM_W-1:0]  in_m,
   input  logic [DIM_W-1:0]  in_n,
   output logic              in_ack,
   input  logic              gen_valid,
   input  logic [FLAT_W-1:0] gen_flat,
   input  logic [DIM_W-1:0]  gen_m,
   input  logic [DIM_W-1:0]  gen_n,
   output logic              gen_overflow,
   input  logic              ovf_clr,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [ELEM_W-1:0] mem_wdata,
   output logic              wr_done,
   output logic              wr_reject,
   output logic [PTR_W-1:0]  wr_slot,
   output logic              busy,
   input  logic [DIM_W-1:0]  q_m,
   input  logic [DIM_W-1:0]  q_n,
   output logic [CNT_W-1:0]  q_count
);
   import matrix_store_arbiter_pkg::*;

   localparam int CLS_W = $clog2(MAX_DIM * MAX_DIM);
   localparam int K_W   = $clog2(MAX_DIM * MAX_DIM + 1);

   state_e            state, state_nxt;
   src_e              cur_src, last_grant, grant_src;
   logic [DIM_W-1:0]  cur_m, cur_n, grant_m, grant_n;
   logic [FLAT_W-1:0] cur_flat, grant_flat;
   logic [K_W-1:0]    k, mn;
   logic [CLS_W-1:0]  cur_cls;
   logic [PTR_W-1:0]  slot_ptr, wr_slot_q;
   logic              cur_reject, in_block, in_present;
   logic              grant_valid, grant_legal, commit_ok, gen_release;
   logic              gen_full;
   logic [FLAT_W-1:0] gen_buf_flat;
   logic [DIM_W-1:0]  gen_buf_m, gen_buf_n;

   assign mn          = K_W'(cur_m) * K_W'(cur_n);
   assign commit_ok   = (state == COMMIT) && !cur_reject;
   assign gen_release = (state == COMMIT) && (cur_src == SRC_GEN);
   assign wr_done     = commit_ok;
   assign wr_reject   = (state == COMMIT) && cur_reject;
   assign in_ack      = (state == COMMIT) && (cur_src == SRC_IN);
   assign wr_slot     = commit_ok ? slot_ptr : wr_slot_q;
   assign busy        = (state != IDLE);

   // in_block hides a still-high in_req for the one IDLE cycle that follows its own ack.
   always_comb begin
      in_present  = in_req && !in_block;
      grant_valid = 1'b0;
      grant_src   = SRC_IN;
      if (state == IDLE) begin
         if (in_present && gen_full) begin
            grant_valid = 1'b1;
            grant_src   = (last_grant == SRC_GEN) ? SRC_IN : SRC_GEN;
         end else if (in_present) begin
            grant_valid = 1'b1;
         end else if (gen_full) begin
            grant_valid = 1'b1;
            grant_src   = SRC_GEN;
         end
      end
      grant_m     = (grant_src == SRC_IN) ? in_m    : gen_buf_m;
      grant_n     = (grant_src == SRC_IN) ? in_n    : gen_buf_n;
      grant_flat  = (grant_src == SRC_IN) ? in_flat : gen_buf_flat;
      grant_legal = grant_m != '0 && grant_m <= DIM_W'(MAX_DIM) &&
                    grant_n != '0 && grant_n <= DIM_W'(MAX_DIM);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_valid) state_nxt = grant_legal ? WRITE : COMMIT;
         WRITE:   if (k == mn - K_W'(1)) state_nxt = COMMIT;
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (state == WRITE) begin
         mem_we    = 1'b1;
         mem_addr  = ADDR_W'(base_addr(int'(cur_m), int'(cur_n), int'(slot_ptr),
                                       MAX_DIM, SLOTS_PER_DIM) + int'(k));
         mem_wdata = cur_flat[int'(k) * ELEM_W +: ELEM_W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cur_src    <= SRC_IN;
         last_grant <= SRC_GEN;
         cur_m      <= '0;
         cur_n      <= '0;
         cur_flat   <= '0;
         cur_cls    <= '0;
         cur_reject <= 1'b0;
         k          <= '0;
         wr_slot_q  <= '0;
         in_block   <= 1'b0;
      end else begin
         state    <= state_nxt;
         in_block <= in_ack;
         if (grant_valid) begin
            cur_src    <= grant_src;
            last_grant <= grant_src;
            cur_m      <= grant_m;
            cur_n      <= grant_n;
            cur_flat   <= grant_flat;
            cur_reject <= !grant_legal;
            cur_cls    <= CLS_W'(class_idx(int'(grant_m), int'(grant_n), MAX_DIM));
            k          <= '0;
         end else if (state == WRITE) begin
            k <= k + 1'b1;
         end
         if (commit_ok)
            wr_slot_q <= slot_ptr;
      end
   end

   // A pulse arriving in the release cycle refills the buffer; an overflow beats a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         gen_full     <= 1'b0;
         gen_buf_flat <= '0;
         gen_buf_m    <= '0;
         gen_buf_n    <= '0;
         gen_overflow <= 1'b0;
      end else begin
         if (gen_valid && (!gen_full || gen_release)) begin
            gen_full     <= 1'b1;
            gen_buf_flat <= gen_flat;
            gen_buf_m    <= gen_m;
            gen_buf_n    <= gen_n;
         end else if (gen_release) begin
            gen_full <= 1'b0;
         end
         if (gen_valid && gen_full && !gen_release)
            gen_overflow <= 1'b1;
         else if (ovf_clr)
            gen_overflow <= 1'b0;
      end
   end

   matrix_slot_table #(
      .MAX_DIM       (MAX_DIM),
      .SLOTS_PER_DIM (SLOTS_PER_DIM)
   ) u_slot_table (
      .clk       (clk),
      .rst       (rst),
      .commit_en (commit_ok),
      .cls       (cur_cls),
      .ptr       (slot_ptr),
      .q_m       (q_m),
      .q_n       (q_n),
      .q_count   (q_count)
   );

endmodule

// File: tb/tb_matrix_store_arbiter.sv
// Scoreboard bench for matrix_store_arbiter: the stimulus pushes the expected RAM writes and commits.
// A negedge monitor pops and compares them whenever the DUT writes or commits.
module tb_matrix_store_arbiter;
   import matrix_store_arbiter_pkg::*;

   logic         clk = 1'b0;
   logic         rst, in_req, gen_valid, ovf_clr;
   logic [199:0] in_flat, gen_flat;
   logic [2:0]   in_m, in_n, gen_m, gen_n, q_m, q_n;
   logic         in_ack, gen_overflow, mem_we, wr_done, wr_reject, busy;
   logic [10:0]  mem_addr;
   logic [7:0]   mem_wdata;
   logic [0:0]   wr_slot;
   logic [1:0]   q_count;

   typedef struct {int addr; int data;} wr_exp_t;
   typedef struct {bit reject; int slot; src_e src;} cm_exp_t;

   wr_exp_t wr_q[$];
   cm_exp_t cm_q[$];
   int      model_cnt[25];
   int      model_ptr[25];
   src_e    model_last;
   int      checks = 0;
   int      errors = 0;
   int      cyc = 0;

   matrix_store_arbiter dut (
      .clk(clk), .rst(rst), .in_req(in_req), .in_flat(in_flat), .in_m(in_m), .in_n(in_n),
      .in_ack(in_ack), .gen_valid(gen_valid), .gen_flat(gen_flat), .gen_m(gen_m), .gen_n(gen_n),
      .gen_overflow(gen_overflow), .ovf_clr(ovf_clr), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .wr_done(wr_done), .wr_reject(wr_reject), .wr_slot(wr_slot),
      .busy(busy), .q_m(q_m), .q_n(q_n), .q_count(q_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // Reference model: RAM layout and slot rotation computed straight from the class/slot rules.
   task automatic model_reset();
      for (int i = 0; i < 25; i++) begin
         model_cnt[i] = 0;
         model_ptr[i] = 0;
      end
      model_last = SRC_GEN;
      wr_q.delete();
      cm_q.delete();
   endtask

   task automatic expect_matrix(input src_e src, input int m, input int n, input logic [199:0] f);
      int cls;
      int slot;
      model_last = src;
      if (m >= 1 && m <= 5 && n >= 1 && n <= 5) begin
         cls  = (m - 1) * 5 + (n - 1);
         slot = model_ptr[cls];
         for (int k = 0; k < m * n; k++)
            wr_q.push_back('{addr: cls * 50 + slot * 25 + k, data: int'(f[k*8 +: 8])});
         cm_q.push_back('{reject: 1'b0, slot: slot, src: src});
         model_ptr[cls] = (slot + 1) % 2;
         if (model_cnt[cls] < 2) model_cnt[cls]++;
      end else begin
         cm_q.push_back('{reject: 1'b1, slot: 0, src: src});
      end
   endtask

   always @(negedge clk) begin
      wr_exp_t we;
      cm_exp_t ce;
      if (!rst) begin
         if (mem_we) begin
            if (wr_q.size() == 0) begin
               check_output("unexpected_write", int'(mem_addr), -1);
            end else begin
               we = wr_q.pop_front();
               check_output("write_addr", int'(mem_addr), we.addr);
               check_output("write_data", int'(mem_wdata), we.data);
            end
         end
         if (wr_done || wr_reject) begin
            if (cm_q.size() == 0) begin
               check_output("unexpected_commit", int'({wr_done, wr_reject}), 0);
            end else begin
               ce = cm_q.pop_front();
               check_output("commit_reject", int'(wr_reject), int'(ce.reject));
               check_output("commit_done", int'(wr_done), int'(!ce.reject));
               if (!ce.reject) check_output("commit_slot", int'(wr_slot), ce.slot);
               check_output("commit_in_ack", int'(in_ack), int'(ce.src == SRC_IN));
            end
         end else if (in_ack) begin
            check_output("unexpected_in_ack", 1, 0);
         end
      end
   end

   // Stimulus tasks are entered at a negedge and return at a negedge.
   task automatic send_input(input int m, input int n, input logic [199:0] f, output int lat);
      int start;
      bit got;
      got     = 1'b0;
      lat     = -1;
      in_req  = 1'b1;
      in_m    = 3'(m);
      in_n    = 3'(n);
      in_flat = f;
      start   = cyc;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (in_ack) begin
            got = 1'b1;
            lat = cyc - start;
         end
      end
      if (!got) check_output("in_ack_timeout", 0, 1);
      repeat (2) @(negedge clk);
      in_req = 1'b0;
   endtask

   task automatic pulse_gen(input int m, input int n, input logic [199:0] f);
      gen_valid = 1'b1;
      gen_m     = 3'(m);
      gen_n     = 3'(n);
      gen_flat  = f;
      @(negedge clk);
      gen_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit idle;
      idle = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 300 && !idle; i++) begin
         if (!busy) idle = 1'b1;
         else @(negedge clk);
      end
      if (!idle) check_output("idle_timeout", int'(busy), 0);
      check_output("scoreboard_drained", wr_q.size() + cm_q.size(), 0);
   endtask

   task automatic check_query(input string name, input int m, input int n, input int expected);
      q_m = 3'(m);
      q_n = 3'(n);
      #1;
      check_output(name, int'(q_count), expected);
   endtask

   function automatic logic [199:0] rand_flat();
      logic [199:0] f;
      for (int i = 0; i < 25; i++) f[i*8 +: 8] = 8'($urandom);
      return f;
   endfunction

   function automatic int pick_dim();
      if ($urandom_range(0, 4) == 0) return int'($urandom_range(0, 7));
      return int'($urandom_range(1, 5));
   endfunction

   initial begin
      logic [199:0] fi, fg;
      int           lat, mode, m, n, gm, gn;

      rst = 1'b1; in_req = 1'b0; gen_valid = 1'b0; ovf_clr = 1'b0;
      in_flat = '0; gen_flat = '0; in_m = '0; in_n = '0; gen_m = '0; gen_n = '0;
      q_m = 3'd2; q_n = 3'd3;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_output("reset_mem_we", int'(mem_we), 0);
      check_output("reset_mem_addr", int'(mem_addr), 0);
      check_output("reset_mem_wdata", int'(mem_wdata), 0);
      check_output("reset_pulses", int'({in_ack, wr_done, wr_reject}), 0);
      check_output("reset_wr_slot", int'(wr_slot), 0);
      check_output("reset_busy", int'(busy), 0);
      check_output("reset_gen_overflow", int'(gen_overflow), 0);
      check_output("reset_q_count", int'(q_count), 0);

      // Input 2x3 with elements 1..6.
      fi = '0;
      for (int i = 0; i < 6; i++) fi[i*8 +: 8] = 8'(i + 1);
      expect_matrix(SRC_IN, 2, 3, fi);
      send_input(2, 3, fi, lat);
      check_output("latency_2x3", lat, 7);
      wait_idle();
      check_query("q_count_2x3", 2, 3, 1);

      // Three 1x1 writes to one class rotate slots 0,1,0.
      for (int i = 0; i < 3; i++) begin
         fi = '0;
         fi[7:0] = (i == 0) ? 8'd4 : (i == 1) ? 8'd7 : 8'd9;
         expect_matrix(SRC_IN, 1, 1, fi);
         send_input(1, 1, fi, lat);
         wait_idle();
      end
      check_query("q_count_1x1_sat", 1, 1, 2);

      // Illegal dimensions are rejected without any RAM write.
      fi = rand_flat();
      expect_matrix(SRC_IN, 0, 3, fi);
      send_input(0, 3, fi, lat);
      check_output("latency_reject", lat, 1);
      wait_idle();
      check_query("q_count_illegal", 0, 3, 0);
      check_query("q_count_2x3_kept", 2, 3, 1);

      // Two generator pulses during a long input write: one buffered, one lost.
      fi = rand_flat();
      fg = rand_flat();
      expect_matrix(SRC_IN, 5, 5, fi);
      expect_matrix(SRC_GEN, 2, 2, fg);
      fork
         send_input(5, 5, fi, lat);
         begin
            repeat (3) @(negedge clk);
            pulse_gen(2, 2, fg);
            repeat (3) @(negedge clk);
            pulse_gen(4, 1, rand_flat());
         end
      join
      wait_idle();
      check_output("gen_overflow_set", int'(gen_overflow), 1);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      check_output("gen_overflow_clr", int'(gen_overflow), 0);

      // Reset during the third element of a 2x2 write: only two writes ever appear.
      fi = rand_flat();
      for (int k = 0; k < 2; k++)
         wr_q.push_back('{addr: 6 * 50 + model_ptr[6] * 25 + k, data: int'(fi[k*8 +: 8])});
      in_req = 1'b1; in_m = 3'd2; in_n = 3'd2; in_flat = fi;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      in_req = 1'b0;
      @(negedge clk);
      check_output("abort_busy", int'(busy), 0);
      check_output("abort_writes_seen", wr_q.size() + cm_q.size(), 0);
      check_query("abort_q_count_2x2", 2, 2, 0);
      check_query("abort_q_count_2x3", 2, 3, 0);
      model_reset();

      // Input and buffered generator in the same IDLE cycle right after reset: input wins.
      fg = rand_flat();
      fi = rand_flat();
      expect_matrix(SRC_IN, 2, 2, fi);
      expect_matrix(SRC_GEN, 3, 3, fg);
      @(negedge clk);
      pulse_gen(3, 3, fg);
      send_input(2, 2, fi, lat);
      wait_idle();
      check_output("rr_no_overflow", int'(gen_overflow), 0);

      // Randomised traffic: input only, generator only, or both contending.
      for (int t = 0; t < 40; t++) begin
         mode = int'($urandom_range(0, 2));
         m  = pick_dim();
         n  = pick_dim();
         gm = pick_dim();
         gn = pick_dim();
         fi = rand_flat();
         fg = rand_flat();
         case (mode)
            0: begin
               expect_matrix(SRC_IN, m, n, fi);
               send_input(m, n, fi, lat);
            end
            1: begin
               expect_matrix(SRC_GEN, gm, gn, fg);
               pulse_gen(gm, gn, fg);
            end
            default: begin
               if (model_last == SRC_GEN) begin
                  expect_matrix(SRC_IN, m, n, fi);
                  expect_matrix(SRC_GEN, gm, gn, fg);
               end else begin
                  expect_matrix(SRC_GEN, gm, gn, fg);
                  expect_matrix(SRC_IN, m, n, fi);
               end
               pulse_gen(gm, gn, fg);
               send_input(m, n, fi, lat);
            end
         endcase
         wait_idle();
      end
      check_query("rand_q_count_2x2", 2, 2, model_cnt[6]);
      check_query("rand_q_count_5x5", 5, 5, model_cnt[24]);
      check_output("rand_no_overflow", int'(gen_overflow), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
